// File: rtl/sub_serial_signed.sv
// Bit-serial signed subtractor z = x - y, one result bit per cycle, LSB first.
// The result is one bit wider than the operands, so it never wraps.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// CALC  | shifting out WIDTH+1 difference bits
// DONE  | z valid, held until out_ready
module sub_serial_signed #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH:0]   z,
  output logic                    busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_opa;
  logic [WIDTH:0]   r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   r_z;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  logic w_sum;
  logic w_cout;

  assign w_sum  = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_cout = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  // Subtraction as x + ~y + 1: the initial carry supplies the +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_opa   <= {x[WIDTH-1], x};
            r_opb   <= ~{y[WIDTH-1], y};
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_cout;
          r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          // z is only updated on completion so it keeps the previous result during CALC.
          if (r_cnt == CNT_LAST) begin
            r_z     <= {w_sum, r_acc};
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign z         = r_z;

endmodule

// File: tb/tb_sub_serial_signed.sv
// Self-checking bench for sub_serial_signed (WIDTH=4): directed table, throughput,
// backpressure, mid-operation reset and a full operand sweep against an arithmetic model.
module tb_sub_serial_signed;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] x;
  logic signed [3:0] y;
  logic              out_valid;
  logic              out_ready;
  logic signed [4:0] z;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  sub_serial_signed #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [3:0] a;
    logic signed [3:0] b;
    int                exp_z;
    int                stall;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full request/response; the source holds in_valid through DONE to show it is ignored.
  task automatic run_op(input logic signed [3:0] a, input logic signed [3:0] b,
                        input int exp_z, input int stall, input string nm);
    int n;
    logic signed [4:0] zh;
    logic stable;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " in_ready before accept"}, int'(in_ready), 1);
    x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 4'($urandom); y = 4'($urandom);
    chk({nm, " busy after accept"}, int'(busy), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      x = 4'($urandom); y = 4'($urandom);
    end
    chk({nm, " latency"}, n, 5);
    chk({nm, " z"}, int'(z), exp_z);
    zh = z;
    stable = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      x = 4'($urandom); y = 4'($urandom);
      if (z !== zh || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) chk({nm, " stall hold"}, int'(stable), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({nm, " idle after retire"}, int'({in_ready, out_valid, busy}), 4);
  endtask

  vec_t vecs[$];
  int   acc_t[$];
  int   expq[$];
  int   done_cnt;
  int   exp_v;
  logic acc;
  logic saw_valid;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    #1;
    chk("reset outputs", int'({in_ready, out_valid, busy}), 4);
    chk("reset z", int'(z), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", int'({in_ready, out_valid, busy}), 4);

    vecs.push_back('{a: 4'sd3,  b: -4'sd4, exp_z: 7,   stall: 0});
    vecs.push_back('{a: -4'sd8, b: 4'sd7,  exp_z: -15, stall: 2});
    vecs.push_back('{a: 4'sd7,  b: -4'sd8, exp_z: 15,  stall: 0});
    vecs.push_back('{a: 4'sd0,  b: 4'sd0,  exp_z: 0,   stall: 1});
    vecs.push_back('{a: -4'sd8, b: -4'sd8, exp_z: 0,   stall: 0});
    vecs.push_back('{a: -4'sd1, b: 4'sd7,  exp_z: -8,  stall: 0});
    vecs.push_back('{a: 4'sd5,  b: -4'sd3, exp_z: 8,   stall: 10});
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_z, vecs[i].stall,
                             $sformatf("vec%0d", i));

    // Reset two cycles into CALC; z still holds +8 from the last vector.
    x = 4'sd2; y = -4'sd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midcalc reset outputs", int'({in_ready, out_valid, busy}), 4);
    chk("midcalc reset z", int'(z), 0);
    @(negedge clk); rst = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("no out_valid after reset", int'(saw_valid), 0);
    run_op(4'sd1, 4'sd2, -1, 0, "after reset");

    // Back-to-back with out_ready tied high: accepts must be 7 cycles apart.
    out_ready = 1'b1; in_valid = 1'b1;
    x = 4'($urandom); y = 4'($urandom);
    done_cnt = 0;
    for (int c = 0; c < 80 && done_cnt < 5; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_t.push_back(c);
        expq.push_back(int'(x) - int'(y));
        x = 4'($urandom); y = 4'($urandom);
      end
      if (out_valid) begin
        if (expq.size() == 0) chk("thr unexpected result", 1, 0);
        else chk("thr z", int'(z), expq.pop_front());
        done_cnt++;
      end
    end
    in_valid = 1'b0;
    chk("thr results", done_cnt, 5);
    chk("thr accepts", acc_t.size(), 5);
    for (int i = 1; i < acc_t.size(); i++) chk("thr spacing", acc_t[i] - acc_t[i-1], 7);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("thr idle", int'({in_ready, out_valid, busy}), 4);

    // Full sweep with random stalls against the arithmetic model.
    for (int xi = -8; xi < 8; xi++) begin
      for (int yi = -8; yi < 8; yi++) begin
        exp_v = xi - yi;
        run_op(4'(xi), 4'(yi), exp_v, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               $sformatf("sweep x=%0d y=%0d", xi, yi));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
